ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-outstanding-pipeline AHB-Lite initiator that converts a simple valid/ready command stream into AHB-Lite single NONSEQ transfers.
- Drives the bus side consumed by AHB peripherals such as the GPIO slave: HADDR, HTRANS, HWRITE, HWDATA, HSEL, HREADY.
- Returns read data and completion on a response strobe.
- Used as the bus-side engine for stimulus and for small on-chip controllers; two-stage pipeline gives back-to-back transfers at one per cycle when the slave is zero-wait.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 256, stall limit; used only with the optional feature

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the HCLK edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  completed transfer was a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  completion was forced by timeout; 0 when the optional feature is off
- HADDR  out  ADDR_W  address-phase address
- HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE
- HWRITE  out  1  address-phase direction
- HSEL  out  1  slave select
- HWDATA  out  DATA_W  data-phase write data
- HREADY  out  1  ready fed back to the slave
- HREADYOUT  in  1  slave ready
- HRDATA  in  DATA_W  slave read data

Behaviour:
- Clock and reset: one clock, HCLK. Reset is synchronous and active-low: all state clears on any HCLK edge with HRESETn=0.
- Reset values: HTRANS=00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, cmd_ready=1 (combinational, see below).
- Pipeline state: address stage (a_v, a_addr, a_write, a_wdata) and data stage (d_v, d_write, d_wdata).
- Address stage drive: HTRANS=10 and HSEL=1 iff a_v, else 00/0. HADDR and HWRITE come from a_addr and a_write, held stable while HREADYOUT=0.
- Data stage drive: HWDATA=d_wdata; it holds its last value when d_v=0.
- HREADY = HREADYOUT (combinational pass; single-slave system).
- cmd_ready = !a_v || HREADYOUT. It is combinational and never depends on cmd_valid.
- Advance rule, at an edge with HREADYOUT=1:
  - Data stage retires (if d_v).
  - Address stage moves to the data stage (d_v<=a_v).
  - An accepted command loads the address stage; with no accepted command, a_v<=0.
- With HREADYOUT=0, both stages hold.
- Completion: at the edge where d_v && HREADYOUT, the next cycle has rsp_valid=1, rsp_write=d_write, rsp_rdata=(d_write?0:HRDATA sampled at that edge). Otherwise rsp_valid=0. rsp_rdata holds its value between pulses.
- Latency: zero-wait read completes with rsp_valid 2 cycles after the acceptance edge. N wait states add N cycles.
- Throughput: 1 transfer/cycle with continuous cmd_valid and HREADYOUT=1.
- State view (derived from a_v,d_v): IDLE(0,0), ADDR(1,0), DATA(0,1), BOTH(1,1). All transitions follow the advance rule. No other states.
- Reset mid-transfer: both stages are dropped, HTRANS goes to IDLE in the cycle after the reset edge, and no rsp_valid is issued for dropped transfers.
- rsp has no backpressure; the consumer must accept every pulse.

Optional Feature:
- Macro: AHB_MASTER_TIMEOUT_EN.
- With the macro: an 8+ bit counter counts consecutive cycles with d_v && !HREADYOUT and resets on HREADYOUT=1.
  - On reaching TIMEOUT_CYCLES: the data stage is forced retired with rsp_valid=1, rsp_err=1, rsp_rdata=0. The address stage is flushed and reported as a second rsp_valid/rsp_err pulse on the following cycle if a_v.
  - A sticky lock then holds cmd_ready=0 and HTRANS=00 until reset.
- Without the macro: no counter, rsp_err tied 0, unbounded stall allowed.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, typedef ahb_cmd_t {write, addr, wdata}, typedef ahb_rsp_t {write, rdata, err}.
- No sub-module required. The timeout counter stays inline under the macro.

Test Plan:
- Reset: hold HRESETn=0 for 2 edges mid-BOTH state -> HTRANS=00, HSEL=0, rsp_valid=0 next cycle; no response for dropped transfers.
- Zero-wait write: addr 0x0000_0004, data 0x0001_ABCD -> HTRANS=10 one cycle, HWDATA=0x0001_ABCD next cycle, rsp_valid with rsp_write=1 the cycle after.
- Read with 3 wait states: addr 0x0, HRDATA=0x0000_1234 on the ready edge -> HADDR held 4 cycles; rsp_rdata=0x0000_1234 with rsp_valid 5 cycles after acceptance.
- Back-to-back: write 0x4 then read 0x0 on consecutive cycles with HREADYOUT=1 -> NONSEQ on 2 consecutive cycles, cmd_ready stays 1, two rsp pulses on consecutive cycles in order.
- Stall backpressure: HREADYOUT=0 while BOTH -> cmd_ready=0, HADDR/HWRITE/HWDATA unchanged until HREADYOUT=1.
- With AHB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16: HREADYOUT stuck 0 -> rsp_err=1 after 16 stalled cycles, then cmd_ready=0 until reset.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer-type encodings and command/response records.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Default-width records for integrators that pass commands/responses as one bundle.
    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_DATA_W = 32;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

    typedef struct packed {
        logic                  write;
        logic [AHB_DATA_W-1:0] rdata;
        logic                  err;
    } ahb_rsp_t;

    // Transfer type driven for a given address-stage occupancy.
    function automatic logic [1:0] htrans_for(input logic busy);
        return busy ? HTRANS_NONSEQ : HTRANS_IDLE;
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ transfers
// through a two-stage (address/data) pipeline, one transfer per cycle at zero wait.
// Optional stall timeout with sticky lock: define AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic              HSEL,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);

    // Address stage
    logic              a_v;
    logic [ADDR_W-1:0] a_addr;
    logic              a_write;
    logic [DATA_W-1:0] a_wdata;
    // Data stage
    logic              d_v;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;

    logic cmd_accept;
    logic flush;      // timeout forces both stages out
    logic lock;       // sticky after a timeout until reset
    logic pend_a;     // flushed address stage still owes a response
    logic pend_write;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_q;

    assign flush = d_v && !HREADYOUT && !lock && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled data-phase cycles; arm the lock and the flushed-address report.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tmo_q      <= '0;
            lock       <= 1'b0;
            pend_a     <= 1'b0;
            pend_write <= 1'b0;
        end else begin
            pend_a <= 1'b0;
            if (flush) begin
                tmo_q      <= '0;
                lock       <= 1'b1;
                pend_a     <= a_v;
                pend_write <= a_write;
            end else if (d_v && !HREADYOUT) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign flush      = 1'b0;
    assign lock       = 1'b0;
    assign pend_a     = 1'b0;
    assign pend_write = 1'b0;
`endif

    // Ready never looks at cmd_valid; an empty address stage can always take a command.
    always_comb begin
        cmd_ready  = (!a_v || HREADYOUT) && !lock;
        cmd_accept = cmd_valid && cmd_ready;
    end

    // Bus-side drive straight from the pipeline registers.
    always_comb begin
        HTRANS = htrans_for(a_v);
        HSEL   = a_v;
        HADDR  = a_addr;
        HWRITE = a_write;
        HWDATA = d_wdata;
        HREADY = HREADYOUT;
    end

    // Pipeline advance: shift on HREADYOUT, otherwise hold (an empty address stage may still fill).
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_v     <= 1'b0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_wdata <= '0;
            d_v     <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (flush) begin
            a_v <= 1'b0;
            d_v <= 1'b0;
        end else begin
            if (HREADYOUT) begin
                d_v <= a_v;
                if (a_v) begin
                    d_write <= a_write;
                    d_wdata <= a_wdata;
                end
                a_v <= cmd_accept;
            end else if (cmd_accept) begin
                a_v <= 1'b1;
            end
            if (cmd_accept) begin
                a_addr  <= cmd_addr;
                a_write <= cmd_write;
                a_wdata <= cmd_wdata;
            end
        end
    end

    // Completion strobe; write/rdata hold between pulses.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b1;
            rsp_write <= d_write;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (pend_a) begin
            rsp_valid <= 1'b1;
            rsp_write <= pend_write;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else begin
            rsp_valid <= d_v && HREADYOUT;
            rsp_err   <= 1'b0;
            if (d_v && HREADYOUT) begin
                rsp_write <= d_write;
                rsp_rdata <= d_write ? '0 : HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master (zero-wait slave modelled by the stimulus).
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    int tests = 0;
    int fails = 0;

    ahb_lite_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSEL      (HSEL),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HREADYOUT = 1'b1; HRDATA = 32'h0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        HRESETn = 1'b1;
        #1;
        tests++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
        tests++; if (HSEL !== 1'b0) begin fails++; $display("FAIL rst_hsel: got %b want 0", HSEL); end
        tests++; if (HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin fails++;
            $display("FAIL rst_bus: got addr %h wr %b wdata %h want 0/0/0", HADDR, HWRITE, HWDATA); end
        tests++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL rst_rsp: got v %b w %b d %h e %b want all 0", rsp_valid, rsp_write, rsp_rdata, rsp_err); end
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        HREADYOUT = 1'b0; #1;
        tests++; if (HREADY !== 1'b0) begin fails++; $display("FAIL hready_pass: got %b want 0", HREADY); end
        HREADYOUT = 1'b1;
    endtask

    task automatic test_write();
        set_cmd(1'b1, 1'b1, 32'h0000_0004, 32'h0001_ABCD);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        tests++; if (HTRANS !== 2'b10 || HSEL !== 1'b1 || HADDR !== 32'h4 || HWRITE !== 1'b1) begin fails++;
            $display("FAIL wr_addr_phase: got t %h s %b a %h w %b want 2/1/4/1", HTRANS, HSEL, HADDR, HWRITE); end
        tick();
        tests++; if (HTRANS !== 2'b00 || HWDATA !== 32'h0001_ABCD || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL wr_data_phase: got t %h wd %h rv %b want 0/0001abcd/0", HTRANS, HWDATA, rsp_valid); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin fails++;
            $display("FAIL wr_rsp: got v %b w %b d %h e %b want 1/1/0/0", rsp_valid, rsp_write, rsp_rdata, rsp_err); end
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_read_wait();
        set_cmd(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        tests++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0 || HADDR !== 32'h0) begin fails++;
            $display("FAIL rd_addr_phase: got t %h w %b a %h want 2/0/0", HTRANS, HWRITE, HADDR); end
        tick();
        HREADYOUT = 1'b0; HRDATA = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0 || HADDR !== 32'h0) begin fails++;
                $display("FAIL rd_wait%0d: got rv %b a %h want 0/0", i, rsp_valid, HADDR); end
        end
        HREADYOUT = 1'b1; HRDATA = 32'h0000_1234;
        tick();
        HRDATA = 32'hFFFF_FFFF;
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0000_1234) begin fails++;
            $display("FAIL rd_rsp: got v %b w %b d %h want 1/0/00001234", rsp_valid, rsp_write, rsp_rdata); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0000_1234) begin fails++;
            $display("FAIL rd_rdata_hold: got v %b d %h want 0/00001234", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        set_cmd(1'b1, 1'b1, 32'h4, 32'h0000_0055);
        tick();
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h4 || HWRITE !== 1'b1) begin fails++;
            $display("FAIL b2b_first: got t %h a %h w %b want 2/4/1", HTRANS, HADDR, HWRITE); end
        set_cmd(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HRDATA = 32'h0000_9876;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h55) begin fails++;
            $display("FAIL b2b_second: got t %h a %h w %b wd %h want 2/0/0/55", HTRANS, HADDR, HWRITE, HWDATA); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || HTRANS !== 2'b00) begin fails++;
            $display("FAIL b2b_rsp1: got v %b w %b d %h t %h want 1/1/0/0", rsp_valid, rsp_write, rsp_rdata, HTRANS); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0000_9876) begin fails++;
            $display("FAIL b2b_rsp2: got v %b w %b d %h want 1/0/00009876", rsp_valid, rsp_write, rsp_rdata); end
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
    endtask

    task automatic test_stall();
        set_cmd(1'b1, 1'b1, 32'h8, 32'h0000_A5A5);
        tick();
        set_cmd(1'b1, 1'b0, 32'hC, 32'h0);
        tick();
        HREADYOUT = 1'b0;
        set_cmd(1'b1, 1'b1, 32'h10, 32'h0000_0077);
        #1;
        tests++; if (cmd_ready !== 1'b0 || HREADY !== 1'b0) begin fails++;
            $display("FAIL stall_ready: got cr %b hr %b want 0/0", cmd_ready, HREADY); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (HADDR !== 32'hC || HWRITE !== 1'b0 || HTRANS !== 2'b10 || HWDATA !== 32'hA5A5 || rsp_valid !== 1'b0) begin
                fails++; $display("FAIL stall_hold%0d: got a %h w %b t %h wd %h rv %b want c/0/2/a5a5/0",
                                  i, HADDR, HWRITE, HTRANS, HWDATA, rsp_valid); end
        end
        HREADYOUT = 1'b1;
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b want 1", cmd_ready); end
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HRDATA = 32'h0000_4321;
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || HADDR !== 32'h10 || HWRITE !== 1'b1) begin fails++;
            $display("FAIL stall_rsp1: got v %b w %b a %h hw %b want 1/1/10/1", rsp_valid, rsp_write, HADDR, HWRITE); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h4321 || HWDATA !== 32'h77) begin fails++;
            $display("FAIL stall_rsp2: got v %b w %b d %h wd %h want 1/0/4321/77", rsp_valid, rsp_write, rsp_rdata, HWDATA); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin fails++;
            $display("FAIL stall_rsp3: got v %b w %b d %h want 1/1/0", rsp_valid, rsp_write, rsp_rdata); end
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL stall_end: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        set_cmd(1'b1, 1'b1, 32'h20, 32'h1);
        tick();
        set_cmd(1'b1, 1'b0, 32'h24, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HREADYOUT = 1'b0;
        tick();
        HRESETn = 1'b0;
        tick();
        tests++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL rmid_idle: got t %h s %b rv %b want 0/0/0", HTRANS, HSEL, rsp_valid); end
        tick();
        HRESETn = 1'b1; HREADYOUT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin fails++;
                $display("FAIL rmid_drop%0d: got rv %b t %h want 0/0", i, rsp_valid, HTRANS); end
        end
    endtask

    task automatic test_timeout();
        set_cmd(1'b1, 1'b1, 32'h30, 32'h0000_00AA);
        tick();
        set_cmd(1'b1, 1'b0, 32'h34, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HREADYOUT = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL tmo_early%0d: got %b want 0", i, rsp_valid); end
        end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || HTRANS !== 2'b00) begin
            fails++; $display("FAIL tmo_data: got v %b e %b w %b d %h t %h want 1/1/1/0/0",
                              rsp_valid, rsp_err, rsp_write, rsp_rdata, HTRANS); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b0) begin fails++;
            $display("FAIL tmo_addr: got v %b e %b w %b want 1/1/0", rsp_valid, rsp_err, rsp_write); end
        HREADYOUT = 1'b1;
        set_cmd(1'b1, 1'b1, 32'h40, 32'h0);
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL tmo_lock: got %b want 0", cmd_ready); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin fails++;
            $display("FAIL tmo_locked_bus: got rv %b t %h want 0/0", rsp_valid, HTRANS); end
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HRESETn = 1'b0;
        tick(); tick();
        HRESETn = 1'b1;
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL tmo_unlock: got %b want 1", cmd_ready); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || HTRANS !== 2'b10) begin fails++;
                $display("FAIL long_stall%0d: got rv %b e %b t %h want 0/0/2", i, rsp_valid, rsp_err, HTRANS); end
        end
        HREADYOUT = 1'b1; HRDATA = 32'h0000_00BB;
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_write !== 1'b1) begin fails++;
            $display("FAIL long_rsp1: got v %b e %b w %b want 1/0/1", rsp_valid, rsp_err, rsp_write); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hBB) begin fails++;
            $display("FAIL long_rsp2: got v %b e %b d %h want 1/0/bb", rsp_valid, rsp_err, rsp_rdata); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
